// File: rtl/seq_mult.sv
// ============================================================================
// Module   : seq_mult
// Purpose  : Unsigned shift-and-add sequential multiplier. One partial
//            product is accumulated per clock and the result is available
//            WIDTH clocks after the start is accepted.
// Ports    : clk   - clock, all state changes on the rising edge
//            rst   - asynchronous active-high reset
//            start - begin a multiply (only looked at in IDLE)
//            A     - unsigned multiplicand, captured on accepted start
//            B     - unsigned multiplier, captured on accepted start
//            P     - registered product, held until the next accepted start
//            busy  - high while iterations are running
//            done  - one-cycle pulse marking P valid
//            eqz   - high when the registered P is zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done,
  output logic               eqz
);

  // Counter must hold values 0..WIDTH-1.
  localparam int c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_m;
  logic [2*WIDTH:0]     r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_eqz;

  // Upper half plus the carry position. Bit 2*WIDTH of the accumulator is
  // always zero at the start of an iteration because the previous shift
  // filled it with zero, so this WIDTH+1 bit sum cannot overflow.
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_acc_next;
  logic [2*WIDTH-1:0]   w_prod;

  always_comb begin
    w_sum = r_acc[2*WIDTH:WIDTH];
    if (r_acc[0]) begin
      w_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, r_m};
    end
    // Add and right shift in one step: the sum (carry included) moves down
    // one place, the low half loses its LSB, zero enters at the top.
    w_acc_next = {1'b0, w_sum, r_acc[WIDTH-1:1]};
    w_prod     = w_acc_next[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eqz   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= A;
            r_acc   <= {1'b0, {WIDTH{1'b0}}, B};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end

        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          // The final iteration's result goes straight into P so that the
          // product is valid on the same edge that raises done.
          if (r_cnt == c_LAST) begin
            r_p     <= w_prod;
            r_eqz   <= (w_prod == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          // Exactly one cycle; start here is dropped, not remembered.
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign P    = r_p;
  assign busy = r_busy;
  assign done = r_done;
  assign eqz  = r_eqz;

endmodule

`default_nettype wire

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; the product is 2*WIDTH bits wide and the internal accumulator is 2*WIDTH+1 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  unsigned multiplicand, captured when start is accepted.
REQ-006 SHALL have port B  input  WIDTH  unsigned multiplier, captured when start is accepted.
REQ-007 SHALL have port P  output  2*WIDTH  product, registered, held stable until the next accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking P valid.
REQ-010 SHALL have port eqz  output  1  high when the registered P equals zero; updates together with P.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE; all three are registered.
REQ-012 SHALL accept start only in IDLE; at that edge it SHALL latch A into register M, load the accumulator with {1'b0, WIDTH zeros, B}, clear the iteration counter, and enter RUN.
REQ-013 In RUN, SHALL perform one iteration per clock: if accumulator bit 0 is 1, add M to accumulator bits [2*WIDTH-1:WIDTH] with the carry into bit 2*WIDTH; then shift the whole (2*WIDTH+1)-bit accumulator right by one, with zero fill; then increment the counter.
REQ-014 The add and the shift SHALL complete in the same cycle, and the carry SHALL never be lost (0xFF*0xFF requires it).
REQ-015 After exactly WIDTH iterations, SHALL load P from accumulator bits [2*WIDTH-1:0], update eqz, and enter DONE.
REQ-016 Latency: if start is accepted at edge k, P and done SHALL be valid after edge k+WIDTH (edge k+8 at default width).
REQ-017 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-018 done SHALL be 1 only in DONE; DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 start asserted in RUN or DONE SHALL be ignored and SHALL not be queued.
REQ-020 Changes on A and B after acceptance SHALL NOT affect the result in progress.
REQ-021 Back-to-back operation: start held high SHALL begin a new operation in the first IDLE cycle after DONE, giving a throughput of one result every WIDTH+2 cycles.
REQ-022 Operand value 0 SHALL still take the full WIDTH iterations; there SHALL be no early termination.

Reset
REQ-023 rst high SHALL immediately, without waiting for clk, force state to IDLE and clear P, counter, accumulator and M to 0; it SHALL force busy=0, done=0 and eqz=1.
REQ-024 rst asserted mid-RUN SHALL abort the operation; done SHALL NOT pulse for it, and after rst falls the first start SHALL be accepted normally.

Verification
REQ-025 Case 1: rst pulse, then A=8'h0F, B=8'h0F, start for 1 cycle -> busy for 8 cycles, done pulse 8 edges after acceptance, P=16'h00E1, eqz=0.
REQ-026 Case 2: A=8'hFF, B=8'hFF -> P=16'hFE01; this checks the carry bit.
REQ-027 Case 3: A=8'h00, B=8'h55 -> P=16'h0000 and eqz=1 at the done pulse, with full 8-cycle latency.
REQ-028 Case 4: start with A=3, B=5, then start re-asserted with A=9, B=9 during RUN -> P=16'h000F, a single done pulse, and no second operation.
REQ-029 Case 5: start with A=8'h12, B=8'h34, then rst asserted mid-RUN, asynchronously between edges -> outputs clear at once, no done pulse; then A=8'h12, B=8'h34 -> P=16'h03A8.
REQ-030 Case 6: start held high, with A=2, B=3 and then A=4, B=5 -> done pulses 10 cycles apart, P=6 then P=20.
